alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width; a power of two and at least 4.
REQ-002 SHALL provide localparam SHW = $clog2(WIDTH), shift/truncate amount width.
REQ-003 SHALL provide port clk  input  1  system clock; all state changes on the rising edge.
REQ-004 SHALL provide port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port in_valid  input  1  request valid.
REQ-006 SHALL provide port in_ready  output  1  block can accept a request.
REQ-007 SHALL provide port op  input  3  operation: 0 AND, 1 OR, 2 XOR, 3 NOT, 4 ADD, 5 SHL, 6 SHR, 7 TRUNC.
REQ-008 SHALL provide ports a, b  input  WIDTH  operands.
REQ-009 SHALL provide port ci  input  1  carry-in; used by ADD only.
REQ-010 SHALL provide port out_valid  output  1  result valid.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL provide port result  output  WIDTH  operation result.
REQ-013 SHALL provide ports co, zero, ovf  output  1 each  carry-out, result==0, signed overflow.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, DONE; in_ready=1 only in IDLE.
REQ-015 SHALL accept a request on in_valid&&in_ready, latch op/a/b/ci, and enter EXEC; in_valid outside IDLE SHALL be ignored.
REQ-016 Ops 0-4 and 7 SHALL complete in exactly one EXEC cycle: out_valid rises on the 1st edge after acceptance.
REQ-017 SHL/SHR SHALL load a counter with b[SHW-1:0], shift one bit per EXEC cycle, and decrement; EXEC SHALL last max(n,1) cycles.
REQ-018 A shift amount of 0 SHALL yield result=a, co=0.
REQ-019 Shifts SHALL be logical and zero-filling; co SHALL be the last bit shifted out.
REQ-020 ADD SHALL compute {co,result}=a+b+ci; ovf SHALL be the signed overflow of that sum; ovf=0 for all other ops.
REQ-021 NOT SHALL be ~a.
REQ-022 For ops 0-3 and 7, co SHALL be 0.
REQ-023 TRUNC with n=b[SHW-1:0] SHALL clear the low n bits of a when b[WIDTH-1]=1, and the high n bits when b[WIDTH-1]=0.
REQ-024 zero SHALL equal (result==0), registered alongside result.
REQ-025 In DONE, out_valid=1 and result/co/zero/ovf SHALL hold stable until out_valid&&out_ready.
REQ-026 After that handshake, the FSM SHALL return to IDLE; in_ready rises on the following cycle, and there is no request overlap.
REQ-027 Outputs SHALL be registered with no combinational path from inputs to outputs, except in_ready, which is decoded from state only.

Reset
REQ-028 rst SHALL asynchronously force IDLE, in_ready=1, out_valid=0, result=0, co=0, zero=0, ovf=0, and counter=0.
REQ-029 Reset during EXEC or DONE SHALL abort the operation with no result delivered; the first request after deassertion SHALL behave normally.

Structure
REQ-030 A shared package alu_pkg SHALL hold the op code localparams (OP_AND..OP_TRUNC) and the FSM state encoding.
REQ-031 Single-cycle ops (0-4, 7) SHALL live in combinational sub-module alu_comb (WIDTH-parametrised); alu_seq SHALL own the FSM, shift counter, and output registers.

Verification (WIDTH=32)
REQ-032 ADD a=FFFFFFFF b=00000001 ci=0 -> result 00000000, co=1, zero=1, ovf=0; out_valid 1 cycle after acceptance.
REQ-033 ADD a=7FFFFFFF b=00000001 ci=0 -> result 80000000, ovf=1, co=0, zero=0.
REQ-034 SHL a=80000001 b=4 -> result 00000010, co=0; in_ready=0 throughout; out_valid exactly 4 cycles after acceptance. Also SHR a=0000000F b=1 -> result 00000007, co=1.
REQ-035 TRUNC a=FFFFFFFF b=80000008 -> FFFFFF00; b=00000008 -> 00FFFFFF; b=80000000 -> FFFFFFFF.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after out_valid while toggling in_valid with a new op -> result stable, request ignored; on out_ready=1, IDLE next cycle.
REQ-037 Assert rst in the 3rd EXEC cycle of SHR b=20 -> out_valid=0 and in_ready=1 immediately; a following AND a=F0F0F0F0 b=FF00FF00 returns F000F000.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes and FSM states.
// Imported by alu_comb and alu_seq.
package alu_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NOT   = 3'd3;
    localparam logic [2:0] OP_ADD   = 3'd4;
    localparam logic [2:0] OP_SHL   = 3'd5;
    localparam logic [2:0] OP_SHR   = 3'd6;
    localparam logic [2:0] OP_TRUNC = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops: AND, OR, XOR, NOT, ADD, TRUNC (shifts yield zero here).
// Ports: op, a, b, ci in; res, co, ovf out. Purely combinational.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] res,
    output logic             co,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   n;
    logic [WIDTH-1:0] ones;

    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    assign n    = b[SHW-1:0];
    assign ones = {WIDTH{1'b1}};

    always_comb begin
        res = '0;
        co  = 1'b0;
        ovf = 1'b0;
        unique case (1'b1)
            op == OP_AND: res = a & b;
            op == OP_OR:  res = a | b;
            op == OP_XOR: res = a ^ b;
            op == OP_NOT: res = ~a;
            op == OP_ADD: begin
                res = sum[WIDTH-1:0];
                co  = sum[WIDTH];
                // same-sign operands producing an opposite-sign sum
                ovf = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (sum[WIDTH-1] != a[WIDTH-1]);
            end
            // b MSB picks which end of a gets n bits cleared
            op == OP_TRUNC: res = b[WIDTH-1] ? (a & (ones << n))
                                             : (a & (ones >> n));
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake; shifts run one bit per cycle.
// Ports: clk, rst, in_valid/in_ready, op, a, b, ci, out_valid/out_ready,
// result, co, zero, ovf (all outputs registered; in_ready from state).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             co,
    output logic             zero,
    output logic             ovf
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state, state_nx;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             ci_q;
    logic [SHW-1:0]   cnt;

    logic             is_shift;
    logic [WIDTH-1:0] sh_nx;
    logic             sh_bit;
    logic [WIDTH-1:0] c_res;
    logic             c_co;
    logic             c_ovf;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op  (op_q),
        .a   (a_q),
        .b   (b_q),
        .ci  (ci_q),
        .res (c_res),
        .co  (c_co),
        .ovf (c_ovf)
    );

    assign is_shift = (op_q == OP_SHL) || (op_q == OP_SHR);
    assign sh_nx    = (op_q == OP_SHL) ? (a_q << 1) : (a_q >> 1);
    assign sh_bit   = (op_q == OP_SHL) ? a_q[WIDTH-1] : a_q[0];

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = EXEC;
            // cnt==0 covers a zero shift amount: one EXEC cycle
            EXEC: if (!is_shift || cnt <= 1) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= OP_AND;
            a_q    <= '0;
            b_q    <= '0;
            ci_q   <= 1'b0;
            cnt    <= '0;
            result <= '0;
            co     <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op_q <= op;
                    a_q  <= a;
                    b_q  <= b;
                    ci_q <= ci;
                    cnt  <= b[SHW-1:0];
                end
                EXEC: if (is_shift) begin
                    if (cnt == '0) begin
                        result <= a_q;
                        co     <= 1'b0;
                        zero   <= (a_q == '0);
                        ovf    <= 1'b0;
                    end else begin
                        a_q <= sh_nx;
                        cnt <= cnt - 1'b1;
                        if (cnt == 1) begin
                            result <= sh_nx;
                            co     <= sh_bit;
                            zero   <= (sh_nx == '0);
                            ovf    <= 1'b0;
                        end
                    end
                end else begin
                    result <= c_res;
                    co     <= c_co;
                    zero   <= (c_res == '0);
                    ovf    <= c_ovf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32).
// Drives on negedge, samples #1 after posedge.
module tb_alu_seq;

    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        co;
    logic        zero;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;
    int lat;
    logic rdy_busy;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .co        (co),
        .zero      (zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // issue one request; return cycles from acceptance edge to out_valid
    task automatic issue(input logic [2:0] o, input logic [31:0] aa,
                         input logic [31:0] bb, input logic c,
                         output int l, output logic busy_rdy);
        @(negedge clk);
        op = o; a = aa; b = bb; ci = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        l = 0;
        busy_rdy = 1'b0;
        while (!out_valid && l < 200) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1;
            l++;
        end
        if (!out_valid) chk("timeout", 64'(l), 64'd0);
    endtask

    task automatic consume;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_out_valid", 64'(out_valid), 64'd0);
        chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic [31:0] aa, input logic [31:0] bb,
                       input logic c, input logic [31:0] er,
                       input logic eco, input logic ez, input logic eov);
        issue(o, aa, bb, c, lat, rdy_busy);
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_co"}, 64'(co), 64'(eco));
        chk({tag, "_zero"}, 64'(zero), 64'(ez));
        chk({tag, "_ovf"}, 64'(ovf), 64'(eov));
        consume();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = OP_AND; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_co", 64'(co), 64'd0);
        chk("rst_zero", 64'(zero), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        @(negedge clk) rst = 1'b0;

        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, lat, rdy_busy);
        chk("add_wrap_lat", 64'(lat), 64'd1);
        chk("add_wrap_res", 64'(result), 64'h0);
        chk("add_wrap_co", 64'(co), 64'd1);
        chk("add_wrap_zero", 64'(zero), 64'd1);
        chk("add_wrap_ovf", 64'(ovf), 64'd0);
        consume();

        run("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0,
            32'h8000_0000, 1'b0, 1'b0, 1'b1);
        run("add_ci", OP_ADD, 32'h1, 32'h2, 1'b1, 32'h4, 1'b0, 1'b0, 1'b0);
        run("add_neg", OP_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0,
            32'h0, 1'b1, 1'b1, 1'b1);

        issue(OP_SHL, 32'h8000_0001, 32'd4, 1'b0, lat, rdy_busy);
        chk("shl_lat", 64'(lat), 64'd4);
        chk("shl_rdy_busy", 64'(rdy_busy), 64'd0);
        chk("shl_res", 64'(result), 64'h10);
        chk("shl_co", 64'(co), 64'd0);
        consume();

        issue(OP_SHR, 32'h0000_000F, 32'd1, 1'b0, lat, rdy_busy);
        chk("shr_lat", 64'(lat), 64'd1);
        chk("shr_res", 64'(result), 64'h7);
        chk("shr_co", 64'(co), 64'd1);
        consume();

        issue(OP_SHL, 32'h1234_5678, 32'h0000_0020, 1'b0, lat, rdy_busy);
        chk("shl0_lat", 64'(lat), 64'd1);
        chk("shl0_res", 64'(result), 64'h1234_5678);
        chk("shl0_co", 64'(co), 64'd0);
        consume();

        run("shl_co", OP_SHL, 32'hC000_0000, 32'd2, 1'b0,
            32'h0, 1'b1, 1'b1, 1'b0);

        run("trunc_lo", OP_TRUNC, 32'hFFFF_FFFF, 32'h8000_0008, 1'b0,
            32'hFFFF_FF00, 1'b0, 1'b0, 1'b0);
        run("trunc_hi", OP_TRUNC, 32'hFFFF_FFFF, 32'h0000_0008, 1'b1,
            32'h00FF_FFFF, 1'b0, 1'b0, 1'b0);
        run("trunc_0", OP_TRUNC, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0,
            32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        run("and", OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1,
            32'h0, 1'b0, 1'b1, 1'b0);
        run("or", OP_OR, 32'h0F0F_0F0F, 32'h00FF_00FF, 1'b0,
            32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0);
        run("xor", OP_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0,
            32'hF0F0_0F0F, 1'b0, 1'b0, 1'b0);
        run("not", OP_NOT, 32'h0, 32'h1234_5678, 1'b1,
            32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);

        // backpressure: result holds, new requests ignored
        issue(OP_XOR, 32'h1111_1111, 32'h2222_2222, 1'b0, lat, rdy_busy);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            op = OP_ADD; a = 32'h5; b = 32'h6;
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_res", 64'(result), 64'h3333_3333);
        end
        @(negedge clk) in_valid = 1'b0;
        consume();
        repeat (2) @(posedge clk);
        #1;
        chk("bp_no_extra", 64'(out_valid), 64'd0);
        chk("bp_idle", 64'(in_ready), 64'd1);

        // reset in the 3rd EXEC cycle of a long shift
        @(negedge clk);
        op = OP_SHR; a = 32'hFFFF_FFFF; b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_result", 64'(result), 64'd0);
        @(negedge clk) rst = 1'b0;

        issue(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, lat, rdy_busy);
        chk("post_rst_lat", 64'(lat), 64'd1);
        chk("post_rst_and", 64'(result), 64'hF000_F000);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
